// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Entry layout is the {pc, inst} pair carried from fetch to decode.
package ifetch_pkg;

  localparam int          FIFO_DEPTH       = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order entry buffer: one-cycle push-to-head latency, push refused when full unless popping.
// Flush empties the buffer on the next edge; reset empties it immediately.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  entry_t       push_dat,
  input  logic         pop,
  input  logic         flush,
  output entry_t       head_dat,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == 2'(FIFO_DEPTH));
  assign empty    = (count == 2'd0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the read side is qualified by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: pc drives a combinational imem, results queue two deep toward decode.
// One-cycle fetch-to-output latency; stalls pc when the buffer is full, redirect flushes it.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          IMEM_ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
)
(
  input  logic                       clk,
  input  logic                       reset,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc
);

  logic [31:0] pc;
  logic [31:0] redirect_tgt;
  logic        fetch_vld;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  fifo_count;
  entry_t      fetch_dat;
  entry_t      head_dat;

  assign imem_addr    = pc[IMEM_ADDR_WIDTH+1:2];
  assign redirect_tgt = align_pc(redirect_pc);

  assign inst_valid = (fifo_count != 2'd0);
  assign pop        = inst_valid & inst_ready;
  assign fetch_vld  = ~redirect & (~fifo_full | pop);
  assign fetch_dat  = '{pc: pc, inst: imem_dout};

  // Head outputs are zeroed when empty so decode never sees stale storage.
  assign inst    = fifo_empty ? 32'h0 : head_dat.inst;
  assign inst_pc = fifo_empty ? 32'h0 : head_dat.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_tgt;
    end else if (fetch_vld) begin
      pc <= pc + PC_STEP;
    end
  end

  ifetch_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fetch_vld),
    .push_dat (fetch_dat),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: expected {pc,inst} pushed when fetch is steered, popped on each handshake.
module tb_ifetch;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic [9:0]  b_imem_addr;
  logic [31:0] b_imem_dout;
  logic        b_inst_valid;
  logic [31:0] b_inst;
  logic [31:0] b_inst_pc;

  logic [31:0] imem [1024];
  assign imem_dout   = imem[imem_addr];
  assign b_imem_dout = imem[b_imem_addr];

  ifetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  ifetch #(.IMEM_ADDR_WIDTH(10), .RESET_PC(32'h0000_0FFC)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (b_imem_addr),
    .imem_dout   (b_imem_dout),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .inst_valid  (b_inst_valid),
    .inst_ready  (1'b1),
    .inst        (b_inst),
    .inst_pc     (b_inst_pc)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] expq [$];
  logic mon_en = 1'b0;
  int   n_xfer = 0;
  int   acc4   = 0;
  logic seen8  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return ((pc >> 2) & 32'h3FF) << 1;
  endfunction

  task automatic push_run(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      expq.push_back({p, exp_inst(p)});
      p = p + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor; a redirect re-seeds the expected stream after this cycle's pop.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (inst_valid && inst_pc == 32'h8) seen8 = 1'b1;
      if (!inst_valid) begin
        chk("idle_inst", inst, 32'h0);
        chk("idle_pc", inst_pc, 32'h0);
      end else if (inst_ready) begin
        n_xfer++;
        if (inst_pc == 32'h4) acc4++;
        if (expq.size() == 0) begin
          chk("extra_xfer", 32'(inst_valid), 32'h0);
        end else begin
          logic [63:0] e;
          e = expq.pop_front();
          chk("xfer_pc", inst_pc, e[63:32]);
          chk("xfer_inst", inst, e[31:0]);
        end
      end
      if (redirect) begin
        expq.delete();
        push_run(align_pc(redirect_pc), 64);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'(2 * i);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_count", 32'(dut.u_fifo.count), 32'h0);
    chk("b_rst_addr", 32'(b_imem_addr), 32'd1023);

    // Streaming from reset, one instruction per cycle from the first edge
    reset      = 1'b0;
    inst_ready = 1'b1;
    push_run(32'h0, 64);
    mon_en     = 1'b1;
    n_xfer     = 0;
    step();
    chk("first_valid", 32'(inst_valid), 32'h1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_inst", inst, 32'h0);
    chk("b_wrap_addr", 32'(b_imem_addr), 32'h0);
    chk("b_head_pc", b_inst_pc, 32'h0000_0FFC);
    chk("b_head_inst", b_inst, 32'd2046);
    step();
    chk("b_next_pc", b_inst_pc, 32'h0000_1000);
    chk("b_next_inst", b_inst, 32'h0);
    for (int i = 0; i < 6; i++) step();
    chk("stream_rate", 32'(n_xfer), 32'd7);

    // Backpressure: saturate, hold pc, drain in order
    reset      = 1'b1;
    inst_ready = 1'b0;
    expq.delete();
    step();
    reset = 1'b0;
    push_run(32'h0, 64);
    for (int i = 0; i < 5; i++) step();
    chk("stall_addr", 32'(imem_addr), 32'h2);
    chk("stall_count", 32'(dut.u_fifo.count), 32'h2);
    chk("stall_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    n_xfer     = 0;
    for (int i = 0; i < 6; i++) step();
    chk("drain_rate", 32'(n_xfer), 32'd6);

    // Redirect while full, unaligned target
    inst_ready = 1'b0;
    step();
    step();
    chk("full_count", 32'(dut.u_fifo.count), 32'h2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("redir_bubble", 32'(inst_valid), 32'h0);
    chk("redir_addr", 32'(imem_addr), 32'd64);
    step();
    chk("redir_valid", 32'(inst_valid), 32'h1);
    chk("redir_pc", inst_pc, 32'h0000_0100);
    chk("redir_inst", inst, 32'h0000_0080);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Redirect coincident with the pop of pc 4
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    acc4     = 0;
    seen8    = 1'b0;
    chk("r0_bubble", 32'(inst_valid), 32'h0);
    step();
    chk("r0_head", inst_pc, 32'h0);
    step();
    chk("r0_head4", inst_pc, 32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("pop_redir_bubble", 32'(inst_valid), 32'h0);
    step();
    chk("pop_redir_pc", inst_pc, 32'h0000_0200);
    chk("pop_redir_inst", inst, exp_inst(32'h0000_0200));
    for (int i = 0; i < 3; i++) step();
    chk("acc4_once", 32'(acc4), 32'h1);
    chk("no_pc8", 32'(seen8), 32'h0);

    // pc wraps modulo 2^32
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_pc_hi", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_hi", inst, 32'd2046);
    step();
    chk("wrap_pc_lo", inst_pc, 32'h0);
    chk("wrap_inst_lo", inst, 32'h0);

    // Asynchronous reset pulse between edges while full
    inst_ready = 1'b0;
    step();
    step();
    chk("pre_rst_count", 32'(dut.u_fifo.count), 32'h2);
    #1;
    reset = 1'b1;
    expq.delete();
    push_run(32'h0, 64);
    #1;
    chk("async_valid", 32'(inst_valid), 32'h0);
    chk("async_inst", inst, 32'h0);
    chk("async_pc", inst_pc, 32'h0);
    #1;
    reset = 1'b0;
    step();
    chk("restart_valid", 32'(inst_valid), 32'h1);
    chk("restart_pc", inst_pc, 32'h0);
    chk("restart_addr", 32'(imem_addr), 32'h1);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    mon_en     = 1'b0;
    inst_ready = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL have parameter IMEM_ADDR_WIDTH, default 10, giving the word-address width of the instruction memory port.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the byte PC loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  IMEM_ADDR_WIDTH  word address to the instruction memory.
REQ-006 imem_dout  input  32  instruction returned combinationally for imem_addr in the same cycle.
REQ-007 redirect  input  1  one-cycle request to restart fetch at redirect_pc (branch/jump).
REQ-008 redirect_pc  input  32  byte target PC, sampled when redirect=1.
REQ-009 inst_valid  output  1  head entry present toward decode.
REQ-010 inst_ready  input  1  decode accepts head entry this cycle.
REQ-011 inst  output  32  head instruction; 32'h0 when inst_valid=0.
REQ-012 inst_pc  output  32  byte PC of head instruction; 32'h0 when inst_valid=0.

Function
REQ-013 The block SHALL hold a 32-bit byte register pc and drive imem_addr = pc[IMEM_ADDR_WIDTH+1:2] combinationally.
REQ-014 The block SHALL buffer fetched {pc, imem_dout} pairs in a 2-entry in-order FIFO whose head drives inst/inst_pc.
REQ-015 pop = inst_valid & inst_ready; push = !redirect & (count<2 | pop); on push, pc SHALL advance by 4.
REQ-016 inst_valid SHALL equal (count != 0); fetch-to-output latency SHALL be one cycle.
REQ-017 When full with no pop, pc and FIFO SHALL hold; imem_addr stays on the stalled pc.
REQ-018 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-019 redirect SHALL take priority: next edge clears FIFO (count=0), loads pc = {redirect_pc[31:2], 2'b00}, no push that cycle.
REQ-020 A pop in the same cycle as redirect SHALL count as a completed transfer; the flush discards only the remaining entries.
REQ-021 After a redirect, inst_valid SHALL be 0 for exactly one cycle, then present the target instruction if no further redirect.
REQ-022 pc SHALL wrap modulo 2^32; imem_addr wraps modulo 2^IMEM_ADDR_WIDTH with no error indication.
REQ-023 redirect_pc[1:0] SHALL be ignored (forced to zero).
REQ-024 Outputs SHALL not combinationally depend on inst_ready or redirect.

Reset
REQ-025 While reset=1: pc=RESET_PC, count=0, FIFO pointers=0, inst_valid=0, inst=0, inst_pc=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-027 First push SHALL occur on the first rising edge after reset deasserts; inst_valid=1 from that edge.

Structure
REQ-028 A shared package ifetch_pkg SHALL define the entry struct {pc[31:0], inst[31:0]}, FIFO depth constant 2, and the reset PC default.
REQ-029 The FIFO SHALL be a sub-module ifetch_fifo (push, pop, flush, full, empty, count), async active-high reset.
REQ-030 RTL SHALL be synthesizable with no simulation-only constructs.

Verification
REQ-031 Bench memory preloaded with word[i]=2*i; reset release, inst_ready=1 -> inst_pc 0,4,8... with inst 0,2,4... one per cycle, starting at the first edge.
REQ-032 inst_ready=0 for 5 cycles after reset -> count saturates at 2, pc holds 32'h8; on release, inst 0,2,4 in order, no loss or duplicate.
REQ-033 redirect=1, redirect_pc=32'h0000_0103 while full -> next cycle inst_valid=0; following cycle inst_pc=32'h100, inst=32'h80.
REQ-034 redirect coincident with a pop of inst_pc=32'h4 -> entry 32'h4 counted accepted once, entry 32'h8 never presented.
REQ-035 RESET_PC=32'hFFC, IMEM_ADDR_WIDTH=10 -> imem_addr 1023 then 0 (pc 32'h1000), inst 2046 then 0.
REQ-036 reset pulsed between edges while count=2 -> inst_valid=0 immediately; after release, fetch restarts at RESET_PC.
